chess_board_renderer: RTL and testbench

CHESS_BOARD_RENDERER -- requirements
Module: chess_board_renderer

---
 rtl/chess_pkg.sv | 51 +++++
 rtl/piece_sprite_rom.sv | 21 ++
 rtl/chess_board_renderer.sv | 160 ++++++++++++++++
 tb/tb_chess_board_renderer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the chess board renderer: square encoding, board
// geometry, palette and the procedural piece sprite shapes.
package chess_pkg;

    typedef enum logic [2:0] {
        PT_NONE    = 3'd0,
        PT_PAWN    = 3'd1,
        PT_KNIGHT  = 3'd2,
        PT_BISHOP  = 3'd3,
        PT_ROOK    = 3'd4,
        PT_QUEEN   = 3'd5,
        PT_KING    = 3'd6,
        PT_INVALID = 3'd7
    } piece_t;

    localparam int OCC_BIT    = 0;
    localparam int COLOUR_BIT = 1;
    localparam int TYPE_LSB   = 2;
    localparam int TYPE_MSB   = 4;

    localparam int BOARD_X0   = 192;
    localparam int BOARD_Y0   = 112;
    localparam int SQ_SIZE    = 32;
    localparam int BOARD_SPAN = 8 * SQ_SIZE;

    localparam logic [23:0] COL_LIGHT    = 24'hF0D9B5;
    localparam logic [23:0] COL_DARK     = 24'hB58863;
    localparam logic [23:0] COL_WHITE_PC = 24'hFFFFFF;
    localparam logic [23:0] COL_BLACK_PC = 24'h202020;
    localparam logic [23:0] COL_CURSOR   = 24'hFF0000;
    localparam logic [23:0] COL_SELECT   = 24'h00FF00;

    // Bit i of a row is drawn at subx = 31-i. Body width grows with piece type;
    // the head sits slightly left of centre so the shape is not mirror-symmetric.
    function automatic logic [31:0] sprite_row(input logic [2:0] ptype, input logic [4:0] suby);
        logic [31:0] bits;
        int          w;
        bits = '0;
        w    = int'(ptype) + 2;
        if (ptype != PT_NONE && ptype != PT_INVALID) begin
            for (int i = 0; i < 32; i++) begin
                if (suby >= 5'd8 && suby <= 5'd27 && i >= 16 - w && i <= 15 + w)
                    bits[i] = 1'b1;
                if (suby >= 5'd4 && suby <= 5'd7 && i >= 14 && i <= 19)
                    bits[i] = 1'b1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/piece_sprite_rom.sv
// Piece bitmap ROM: six 32x32 sprites addressed by {type, suby}, one-cycle
// registered read; the unused type codes read as all zeros.
module piece_sprite_rom
    import chess_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr_i,
    output logic [31:0] data_o
);

    logic [31:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= sprite_row(addr_i[7:5], addr_i[4:0]);
    end

    assign data_o = data_q;

endmodule

// File: rtl/chess_board_renderer.sv
// Three-stage pixel pipeline drawing an 8x8 chess board with piece sprites,
// cursor and selection borders; syncs and blank are delayed to match rgb.
module chess_board_renderer
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_b_i,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [4:0] rd_data,
    input  logic [2:0] cursor_row,
    input  logic [2:0] cursor_col,
    input  logic       sel_valid,
    input  logic [2:0] sel_row,
    input  logic [2:0] sel_col,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_b,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    typedef struct packed {
        logic       in_board;
        logic [2:0] row;
        logic [2:0] col;
        logic [4:0] subx;
        logic [4:0] suby;
        logic       cursor;
        logic       sel;
        logic       hs;
        logic       vs;
        logic       bl;
    } s1_t;

    typedef struct packed {
        logic       in_board;
        logic       light;
        logic       border;
        logic       cursor;
        logic       sel;
        logic       occ;
        logic       black;
        piece_t     ptype;
        logic [4:0] subx;
        logic       hs;
        logic       vs;
        logic       bl;
    } s2_t;

    localparam s1_t S1_RST = '{in_board: 1'b0, row: 3'd0, col: 3'd0, subx: 5'd0, suby: 5'd0,
                               cursor: 1'b0, sel: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0};
    localparam s2_t S2_RST = '{in_board: 1'b0, light: 1'b0, border: 1'b0, cursor: 1'b0,
                               sel: 1'b0, occ: 1'b0, black: 1'b0, ptype: PT_NONE,
                               subx: 5'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0};

    logic [7:0]  dx, dy;
    logic        in_board;
    s1_t         s1_d, s1_q;
    s2_t         s2_d, s2_q;
    logic [31:0] sprite_bits;
    logic        piece_px;
    logic [23:0] rgb_d, rgb_q;
    logic        hs_q, vs_q, bl_q;
    logic [2:0]  rd_row_q, rd_col_q;

    // Only the low 8 bits of the offset matter inside the 256-pixel board.
    always_comb begin
        dx       = x[7:0] - 8'(BOARD_X0);
        dy       = y[7:0] - 8'(BOARD_Y0);
        in_board = (x >= 10'(BOARD_X0)) && (x < 10'(BOARD_X0 + BOARD_SPAN)) &&
                   (y >= 10'(BOARD_Y0)) && (y < 10'(BOARD_Y0 + BOARD_SPAN));
        s1_d.in_board = in_board;
        s1_d.row      = dy[7:5];
        s1_d.col      = dx[7:5];
        s1_d.subx     = dx[4:0];
        s1_d.suby     = dy[4:0];
        s1_d.cursor   = (dy[7:5] == cursor_row) && (dx[7:5] == cursor_col);
        s1_d.sel      = sel_valid && (dy[7:5] == sel_row) && (dx[7:5] == sel_col);
        s1_d.hs       = hsync_i;
        s1_d.vs       = vsync_i;
        s1_d.bl       = blank_b_i;
    end

    always_comb begin
        s2_d.in_board = s1_q.in_board;
        s2_d.light    = ~(s1_q.row[0] ^ s1_q.col[0]);
        s2_d.border   = (s1_q.subx == 5'd0) || (s1_q.subx == 5'd31) ||
                        (s1_q.suby == 5'd0) || (s1_q.suby == 5'd31);
        s2_d.cursor   = s1_q.cursor;
        s2_d.sel      = s1_q.sel;
        s2_d.occ      = rd_data[OCC_BIT];
        s2_d.black    = rd_data[COLOUR_BIT];
        s2_d.ptype    = piece_t'(rd_data[TYPE_MSB:TYPE_LSB]);
        s2_d.subx     = s1_q.subx;
        s2_d.hs       = s1_q.hs;
        s2_d.vs       = s1_q.vs;
        s2_d.bl       = s1_q.bl;
    end

    piece_sprite_rom u_rom (
        .clk    (clk),
        .reset  (reset),
        .addr_i ({rd_data[TYPE_MSB:TYPE_LSB], s1_q.suby}),
        .data_o (sprite_bits)
    );

    // Priority: blanking/off-board, cursor border, select border, piece, square.
    always_comb begin
        piece_px = s2_q.occ && (s2_q.ptype != PT_NONE) && (s2_q.ptype != PT_INVALID) &&
                   sprite_bits[5'd31 - s2_q.subx];
        rgb_d = '0;
        if (!s2_q.bl || !s2_q.in_board)      rgb_d = '0;
        else if (s2_q.border && s2_q.cursor) rgb_d = COL_CURSOR;
        else if (s2_q.border && s2_q.sel)    rgb_d = COL_SELECT;
        else if (piece_px)                   rgb_d = s2_q.black ? COL_BLACK_PC : COL_WHITE_PC;
        else                                 rgb_d = s2_q.light ? COL_LIGHT : COL_DARK;
    end

    // NOTE: reset clears every datapath stage too, so pixels in flight are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= S1_RST;
            s2_q     <= S2_RST;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            bl_q     <= 1'b0;
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            rgb_q <= rgb_d;
            hs_q  <= s2_q.hs;
            vs_q  <= s2_q.vs;
            bl_q  <= s2_q.bl;
            if (in_board) begin
                rd_row_q <= s1_d.row;
                rd_col_q <= s1_d.col;
            end
        end
    end

    assign rd_row  = rd_row_q;
    assign rd_col  = rd_col_q;
    assign hsync   = hs_q;
    assign vsync   = vs_q;
    assign blank_b = bl_q;
    assign r       = rgb_q[23:16];
    assign g       = rgb_q[15:8];
    assign b       = rgb_q[7:0];

endmodule

// File: tb/tb_chess_board_renderer.sv
// Self-checking bench: directed board scenarios plus random pixels compared
// against a geometric reference model three cycles later.
module tb_chess_board_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       hsync_i = 1'b1, vsync_i = 1'b1, blank_b_i = 1'b0;
    logic [2:0] rd_row, rd_col;
    logic [4:0] rd_data;
    logic [2:0] cursor_row = 3'd7, cursor_col = 3'd7;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_row = 3'd0, sel_col = 3'd0;
    logic       hsync, vsync, blank_b;
    logic [7:0] r, g, b;

    logic [4:0] board [8][8];
    assign rd_data = board[rd_row][rd_col];

    always #5 clk = ~clk;

    chess_board_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .blank_b_i  (blank_b_i),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .sel_valid  (sel_valid),
        .sel_row    (sel_row),
        .sel_col    (sel_col),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_b    (blank_b),
        .r          (r),
        .g          (g),
        .b          (b)
    );

    typedef struct {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cr = 7, cc = 7, sr = 0, sc = 0;
    bit   sv = 1'b0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit sprite_on(input int t, input int sx, input int sy);
        int w;
        w = t + 2;
        return (sy >= 8 && sy <= 27 && sx >= 16 - w && sx <= 15 + w) ||
               (sy >= 4 && sy <= 7 && sx >= 12 && sx <= 17);
    endfunction

    function automatic logic [23:0] model(input int px, input int py, input bit bl);
        int dx, dy, row, col, sx, sy, sq, t;
        bit border;
        if (!bl) return 24'h0;
        if (px < 192 || px > 447 || py < 112 || py > 367) return 24'h0;
        dx = px - 192;  dy = py - 112;
        row = dy / 32;  col = dx / 32;
        sx = dx % 32;   sy = dy % 32;
        border = (sx == 0 || sx == 31 || sy == 0 || sy == 31);
        if (border && row == cr && col == cc) return 24'hFF0000;
        if (border && sv && row == sr && col == sc) return 24'h00FF00;
        sq = int'(board[row][col]);
        t  = sq / 4;
        if ((sq % 2) == 1 && t >= 1 && t <= 6 && sprite_on(t, sx, sy))
            return ((sq / 2) % 2 == 1) ? 24'h202020 : 24'hFFFFFF;
        return ((row + col) % 2 == 1) ? 24'hB58863 : 24'hF0D9B5;
    endfunction

    task automatic step(input int px, input int py, input bit bl,
                        input bit hs = 1'b1, input bit vs = 1'b1,
                        input bit use_exp = 1'b0, input logic [23:0] exp_rgb = 24'h0,
                        input string tag = "rand");
        exp_t e;
        @(negedge clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            check({e.tag, "/hsync"},   24'(hsync),   24'(e.hs));
            check({e.tag, "/vsync"},   24'(vsync),   24'(e.vs));
            check({e.tag, "/blank_b"}, 24'(blank_b), 24'(e.bl));
            check({e.tag, "/rgb"},     {r, g, b},    e.rgb);
        end
        reset      = 1'b0;
        x          = 10'(px);
        y          = 10'(py);
        blank_b_i  = bl;
        hsync_i    = hs;
        vsync_i    = vs;
        cursor_row = 3'(cr);
        cursor_col = 3'(cc);
        sel_valid  = sv;
        sel_row    = 3'(sr);
        sel_col    = 3'(sc);
        e.hs  = hs;
        e.vs  = vs;
        e.bl  = bl;
        e.rgb = use_exp ? exp_rgb : model(px, py, bl);
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic set_square(input int row, input int col, input logic [4:0] v);
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        board[row][col] = v;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset     = 1'b1;
        x         = 10'd300;
        y         = 10'd200;
        blank_b_i = 1'b1;
        hsync_i   = 1'b1;
        vsync_i   = 1'b1;
        q.delete();
        @(negedge clk);
        check("rst/rgb",     {r, g, b},     24'h0);
        check("rst/hsync",   24'(hsync),    24'h1);
        check("rst/vsync",   24'(vsync),    24'h1);
        check("rst/blank_b", 24'(blank_b),  24'h0);
        check("rst/rd_row",  24'(rd_row),   24'h0);
        check("rst/rd_col",  24'(rd_col),   24'h0);
        e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.rgb = 24'h0; e.tag = "post_rst";
        repeat (3) q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                board[i][j] = 5'($urandom_range(31, 0));

        do_reset();

        // Square (0,0) plain, then cursor and selection borders.
        set_square(0, 0, 5'b00000);
        step(192, 112, 1'b1, 1'b1, 1'b1, 1'b1, 24'hF0D9B5, "light00");
        cr = 0; cc = 0;
        step(192, 112, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF0000, "cursor00");
        sv = 1'b1; sr = 0; sc = 0;
        step(192, 112, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF0000, "cur_over_sel");
        cr = 7; cc = 7;
        step(192, 112, 1'b1, 1'b1, 1'b1, 1'b1, 24'h00FF00, "sel00");
        step(208, 112, 1'b1, 1'b1, 1'b1, 1'b1, 24'h00FF00, "sel00_top");
        sv = 1'b0;

        // Square (7,0) interior with rook variants and an invalid type.
        set_square(7, 0, 5'b10001);
        step(208, 352, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, "white_rook");
        set_square(7, 0, 5'b10011);
        step(208, 352, 1'b1, 1'b1, 1'b1, 1'b1, 24'h202020, "black_rook");
        set_square(7, 0, 5'b11101);
        step(208, 352, 1'b1, 1'b1, 1'b1, 1'b1, 24'hB58863, "type7");
        set_square(7, 0, 5'b10000);
        step(208, 352, 1'b1, 1'b1, 1'b1, 1'b1, 24'hB58863, "unoccupied");

        // Column edges on y = 200.
        step(191, 200, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, "x191");
        step(448, 200, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, "x448");
        step(447, 200, 1'b1, 1'b1, 1'b1, 1'b1, 24'hB58863, "x447");
        step(192, 200, 1'b1, 1'b1, 1'b1, 1'b1, 24'hF0D9B5, "x192");
        step(300, 200, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, "blank_in_board");

        // 96-cycle hsync pulse over a visible, partly blanked line.
        for (int i = 0; i < 110; i++)
            step($urandom_range(460, 180), 240, (i % 9) != 0,
                 !(i >= 5 && i < 101), 1'b1, 1'b0, 24'h0, "hsync_pulse");

        // Random pixels with mid-frame cursor/selection changes.
        for (int i = 0; i < 1500; i++) begin
            if ((i % 17) == 0) begin
                cr = $urandom_range(7, 0); cc = $urandom_range(7, 0);
                sr = $urandom_range(7, 0); sc = $urandom_range(7, 0);
                sv = 1'($urandom_range(1, 0));
            end
            step($urandom_range(460, 180), $urandom_range(380, 100),
                 $urandom_range(7, 0) != 0, $urandom_range(15, 0) != 0,
                 $urandom_range(31, 0) != 0);
        end

        // Reset in the middle of a visible line, then resume.
        for (int i = 0; i < 20; i++)
            step(380 + i, 300, 1'b1);
        do_reset();
        for (int i = 0; i < 40; i++)
            step(192 + 6 * i, 250, 1'b1);

        repeat (3) step(0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
